wb_serial_fifo_bridge: RTL and testbench
========================================

WB_SERIAL_FIFO_BRIDGE -- requirements
Module: wb_serial_fifo_bridge

Interface
REQ-001 SHALL have parameters: NUM_CH (default 2), number of independent byte-stream channels, 1..4.
REQ-002 SHALL have parameter DATA_W (default 8), stream data width, 8/16/32.
REQ-003 SHALL have parameter DEPTH_LOG2 (default 9), log2 of per-direction FIFO depth.
REQ-004 SHALL have parameter EMPTY_READ_VALUE (default 32'hBAD_FAB_AC), data returned on empty-FIFO read.
REQ-005 SHALL have ports: WBs_CLK_i  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port WBs_RSTn_i  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have Wishbone slave ports: WBs_ADR_i in 4 (word address: [3:2] channel, [1:0] register); WBs_CYC_i in 1; WBs_STB_i in 1; WBs_WE_i in 1; WBs_BYTE_STB_i in 4; WBs_DAT_i in 32; WBs_DAT_o out 32; WBs_ACK_o out 1.
REQ-008 SHALL have stream-side ports: rx_data_i in NUM_CH*DATA_W, rx_valid_i in NUM_CH, rx_ready_o out NUM_CH (peripheral-to-M4); tx_data_o out NUM_CH*DATA_W, tx_valid_o out NUM_CH, tx_ready_i in NUM_CH (M4-to-peripheral).
REQ-009 SHALL have port Interrupt_o  out  1  level interrupt to M4.

Function
REQ-010 SHALL assert WBs_ACK_o for exactly one cycle, one cycle after CYC&STB rise; no ACK while ACK is high; back-to-back transfers ACK every second cycle.
REQ-011 SHALL drive WBs_DAT_o valid in the ACK cycle; side effects (push/pop/W1C) SHALL occur only in the ACK cycle, once per transfer.
REQ-012 Register 0 DATA: read pops channel RX FIFO (zero-extended); write pushes WBs_DAT_i[DATA_W-1:0] into TX FIFO.
REQ-013 Register 1 STATUS (RO): [15:0] RX level, [31:16] TX free space, each DEPTH_LOG2+1 bits zero-extended.
REQ-014 Register 2 CTRL (RW): [3:0] irq enables, [15:8] RX threshold, [23:16] TX threshold, [24] loopback.
REQ-015 Register 3 IRQ_STAT: [0] RX level>=RX threshold (live), [1] TX level<=TX threshold (live), [2] overflow sticky, [3] underflow sticky; write 1 clears sticky bits.
REQ-016 Channel index >= NUM_CH SHALL read EMPTY_READ_VALUE, ACK normally, ignore writes.
REQ-017 Read of DATA when RX empty SHALL return EMPTY_READ_VALUE, not pop, set underflow.
REQ-018 Write of DATA when TX full SHALL drop the word and set overflow.
REQ-019 rx_ready_o SHALL equal RX not-full; transfer on rx_valid_i&rx_ready_o; never drops.
REQ-020 tx_valid_o SHALL equal TX not-empty with tx_data_o = FIFO head (first-word-fall-through); pop on tx_valid_o&tx_ready_i.
REQ-021 Simultaneous push and pop on one FIFO SHALL leave level unchanged, valid when full or empty.
REQ-022 Loopback=1 SHALL route TX FIFO head into RX FIFO internally, force rx_ready_o=0 and tx_valid_o=0.
REQ-023 Interrupt_o SHALL be registered OR over channels of (IRQ_STAT & enables); one-cycle latency.
REQ-024 Pointers SHALL wrap modulo 2^DEPTH_LOG2; level counters SHALL saturate at 0 and depth by construction.

Reset
REQ-025 On WBs_RSTn_i low, asynchronously: FIFOs empty, CTRL=0, sticky bits=0, WBs_ACK_o=0, WBs_DAT_o=0, Interrupt_o=0, tx_valid_o=0, rx_ready_o=0.
REQ-026 Reset mid-transfer SHALL abort it; no push/pop; first ACK after release requires a fresh CYC&STB.
REQ-027 rx_ready_o SHALL rise the first cycle after reset release.

Configuration
REQ-028 Macro WB_FIFO_BRIDGE_DROP_CNT_EN defined: IRQ_STAT[15:8] SHALL be an 8-bit saturating count of dropped TX writes, cleared by writing 1 to bit 2.
REQ-029 Macro undefined: IRQ_STAT[15:8] SHALL read 0; no counter logic.

Structure
REQ-030 Shared package SHALL hold register offsets, CTRL/IRQ_STAT bit positions and EMPTY_READ_VALUE default.
REQ-031 SHALL instantiate sub-module wb_bridge_sync_fifo (parameters DATA_W, DEPTH_LOG2; push/pop/full/empty/level) twice per channel.

Verification
REQ-032 Push 0x11,0x22,0x33 on rx ch0, read DATA x3 -> 0x11,0x22,0x33; fourth read -> 0xBADFABAC, IRQ_STAT[3]=1.
REQ-033 DEPTH_LOG2=2: write 5 words to ch1 DATA with tx_ready_i=0 -> STATUS[31:16]=0, IRQ_STAT[2]=1, 5th word never appears on tx_data_o.
REQ-034 CTRL ch0 = RX threshold 2, enable bit0; push 2 bytes -> Interrupt_o high next cycle; read 1 -> Interrupt_o low.
REQ-035 Loopback ch0, write 0xA5 -> tx_valid_o stays 0; DATA read returns 0xA5.
REQ-036 Full RX FIFO with rx_valid_i and DATA read in same cycle -> level unchanged, rx_ready_o stays 0 then rises.
REQ-037 Assert WBs_RSTn_i during pending write -> no ACK, FIFO empty, all outputs at REQ-025 values.

Source files
------------

// File: rtl/wb_serial_fifo_bridge_pkg.sv
// Shared definitions for the Wishbone serial FIFO bridge: register map,
// CTRL / IRQ_STAT field positions and the default empty-read pattern.
package wb_serial_fifo_bridge_pkg;

   // Register selector, word address bits [1:0]
   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_IRQ    = 2'd3
   } reg_e;

   // CTRL field positions
   localparam int CTRL_IEN_LSB    = 0;
   localparam int CTRL_RX_THR_LSB = 8;
   localparam int CTRL_TX_THR_LSB = 16;
   localparam int CTRL_LB_BIT     = 24;

   // IRQ_STAT field positions
   localparam int IRQ_RX_BIT   = 0;
   localparam int IRQ_TX_BIT   = 1;
   localparam int IRQ_OVF_BIT  = 2;
   localparam int IRQ_UDF_BIT  = 3;
   localparam int IRQ_DROP_LSB = 8;

   localparam logic [31:0] EMPTY_READ_VALUE_DFLT = 32'hBADF_ABAC;

   // Per-channel control register contents
   typedef struct packed {
      logic       lb;
      logic [7:0] tx_thr;
      logic [7:0] rx_thr;
      logic [3:0] ien;
   } ctrl_t;

endpackage

// File: rtl/wb_bridge_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level output.
// A pop of an empty FIFO is ignored; a push while full is accepted only
// when a pop happens in the same cycle.
module wb_bridge_sync_fifo #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_push,
   input  logic [DATA_W-1:0]     i_push_data,
   input  logic                  i_pop,
   output logic [DATA_W-1:0]     o_head,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DEPTH_LOG2:0]   o_level
);

   logic [DATA_W-1:0]     r_mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_level;
   logic                  w_do_push;
   logic                  w_do_pop;

   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Storage write
   // NOTE: the memory array has no reset; pointers and level decide which entries are meaningful.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   // Pointer and level bookkeeping; pointers wrap naturally at 2^DEPTH_LOG2
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
         if (w_do_push && !w_do_pop)      r_level <= r_level + (DEPTH_LOG2+1)'(1);
         else if (w_do_pop && !w_do_push) r_level <= r_level - (DEPTH_LOG2+1)'(1);
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = r_level[DEPTH_LOG2];
   assign o_empty = (r_level == '0);
   assign o_level = r_level;

endmodule

// File: rtl/wb_serial_fifo_bridge.sv
// Wishbone slave bridging the M4 to NUM_CH byte-stream channels, each with
// an RX (peripheral->M4) and TX (M4->peripheral) FIFO, per-channel CTRL,
// live/sticky interrupt status and a registered interrupt line.
// Optional: define WB_FIFO_BRIDGE_DROP_CNT_EN for an 8-bit saturating count
// of dropped TX writes in IRQ_STAT[15:8].
module wb_serial_fifo_bridge
   import wb_serial_fifo_bridge_pkg::*;
#(
   parameter int          NUM_CH           = 2,
   parameter int          DATA_W           = 8,
   parameter int          DEPTH_LOG2       = 9,
   parameter logic [31:0] EMPTY_READ_VALUE = EMPTY_READ_VALUE_DFLT
) (
   input  logic                     WBs_CLK_i,
   input  logic                     WBs_RSTn_i,
   input  logic [3:0]               WBs_ADR_i,
   input  logic                     WBs_CYC_i,
   input  logic                     WBs_STB_i,
   input  logic                     WBs_WE_i,
   input  logic [3:0]               WBs_BYTE_STB_i,
   input  logic [31:0]              WBs_DAT_i,
   output logic [31:0]              WBs_DAT_o,
   output logic                     WBs_ACK_o,
   input  logic [NUM_CH*DATA_W-1:0] rx_data_i,
   input  logic [NUM_CH-1:0]        rx_valid_i,
   output logic [NUM_CH-1:0]        rx_ready_o,
   output logic [NUM_CH*DATA_W-1:0] tx_data_o,
   output logic [NUM_CH-1:0]        tx_valid_o,
   input  logic [NUM_CH-1:0]        tx_ready_i,
   output logic                     Interrupt_o
);

   localparam int                LVL_W = DEPTH_LOG2 + 1;
   localparam logic [LVL_W-1:0] DEPTH = LVL_W'(2**DEPTH_LOG2);

   logic                 r_ack;
   logic                 r_run;
   logic                 r_irq;
   logic [1:0]           w_ch;
   reg_e                 w_reg;
   logic                 w_acc;
   logic [NUM_CH*32-1:0] w_rd_words;
   logic [NUM_CH-1:0]    w_irq_ch;
   logic [31:0]          w_rd_mux;
   logic                 w_unused_dat;

   assign w_ch         = WBs_ADR_i[3:2];
   assign w_reg        = reg_e'(WBs_ADR_i[1:0]);
   // Side effects happen only in the ACK cycle of a still-active transfer
   assign w_acc        = r_ack & WBs_CYC_i & WBs_STB_i;
   assign w_unused_dat = ^WBs_DAT_i;

   // ACK one cycle after request, never two in a row; run flag gates the stream side after reset
   always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
      if (!WBs_RSTn_i) begin
         r_ack <= 1'b0;
         r_run <= 1'b0;
         r_irq <= 1'b0;
      end else begin
         r_ack <= WBs_CYC_i & WBs_STB_i & ~r_ack & r_run;
         r_run <= 1'b1;
         r_irq <= |w_irq_ch;
      end
   end

   for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
      logic              w_hit, w_wr_data, w_rd_data, w_wr_ctrl, w_wr_irq;
      logic              w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
      logic              w_tx_pop, w_tx_full, w_tx_empty, w_lb_xfer;
      logic              w_ovf_set, w_udf_set, w_clr_ovf, w_clr_udf;
      logic [DATA_W-1:0] w_rx_din, w_rx_head, w_tx_head;
      logic [LVL_W-1:0]  w_rx_level, w_tx_level;
      logic [3:0]        w_irq_stat;
      logic [7:0]        w_drop;
      logic [31:0]       w_word;
      ctrl_t             r_ctrl;
      logic              r_ovf, r_udf;

      assign w_hit     = w_acc & (w_ch == 2'(gc));
      assign w_wr_data = w_hit &  WBs_WE_i & (w_reg == REG_DATA);
      assign w_rd_data = w_hit & ~WBs_WE_i & (w_reg == REG_DATA);
      assign w_wr_ctrl = w_hit &  WBs_WE_i & (w_reg == REG_CTRL);
      assign w_wr_irq  = w_hit &  WBs_WE_i & (w_reg == REG_IRQ) & WBs_BYTE_STB_i[0];

      // Loopback moves the TX head into RX whenever both sides allow it
      assign w_lb_xfer = r_ctrl.lb & ~w_tx_empty & ~w_rx_full;
      assign w_rx_push = (rx_valid_i[gc] & rx_ready_o[gc]) | w_lb_xfer;
      assign w_rx_din  = r_ctrl.lb ? w_tx_head : rx_data_i[gc*DATA_W +: DATA_W];
      assign w_rx_pop  = w_rd_data & ~w_rx_empty;
      assign w_tx_pop  = w_lb_xfer | (tx_valid_o[gc] & tx_ready_i[gc]);

      assign w_ovf_set = w_wr_data & w_tx_full & ~w_tx_pop;
      assign w_udf_set = w_rd_data & w_rx_empty;
      assign w_clr_ovf = w_wr_irq & WBs_DAT_i[IRQ_OVF_BIT];
      assign w_clr_udf = w_wr_irq & WBs_DAT_i[IRQ_UDF_BIT];

      wb_bridge_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
         .i_clk(WBs_CLK_i), .i_rst_n(WBs_RSTn_i),
         .i_push(w_rx_push), .i_push_data(w_rx_din), .i_pop(w_rx_pop),
         .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_level(w_rx_level)
      );

      wb_bridge_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
         .i_clk(WBs_CLK_i), .i_rst_n(WBs_RSTn_i),
         .i_push(w_wr_data), .i_push_data(WBs_DAT_i[DATA_W-1:0]), .i_pop(w_tx_pop),
         .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_level(w_tx_level)
      );

      // CTRL register with byte-lane write enables; sticky flags with write-1-to-clear
      always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
         if (!WBs_RSTn_i) begin
            r_ctrl <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
         end else begin
            if (w_wr_ctrl) begin
               if (WBs_BYTE_STB_i[0]) r_ctrl.ien    <= WBs_DAT_i[CTRL_IEN_LSB +: 4];
               if (WBs_BYTE_STB_i[1]) r_ctrl.rx_thr <= WBs_DAT_i[CTRL_RX_THR_LSB +: 8];
               if (WBs_BYTE_STB_i[2]) r_ctrl.tx_thr <= WBs_DAT_i[CTRL_TX_THR_LSB +: 8];
               if (WBs_BYTE_STB_i[3]) r_ctrl.lb     <= WBs_DAT_i[CTRL_LB_BIT];
            end
            r_ovf <= (r_ovf & ~w_clr_ovf) | w_ovf_set;
            r_udf <= (r_udf & ~w_clr_udf) | w_udf_set;
         end
      end

`ifdef WB_FIFO_BRIDGE_DROP_CNT_EN
      logic [7:0] r_drop;

      // Saturating count of dropped TX writes, cleared alongside the overflow flag
      always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
         if (!WBs_RSTn_i)                     r_drop <= '0;
         else if (w_clr_ovf)                  r_drop <= '0;
         else if (w_ovf_set && r_drop != '1) r_drop <= r_drop + 8'd1;
      end

      assign w_drop = r_drop;
`else
      assign w_drop = '0;
`endif

      assign w_irq_stat[IRQ_RX_BIT]  = 16'(w_rx_level) >= 16'(r_ctrl.rx_thr);
      assign w_irq_stat[IRQ_TX_BIT]  = 16'(w_tx_level) <= 16'(r_ctrl.tx_thr);
      assign w_irq_stat[IRQ_OVF_BIT] = r_ovf;
      assign w_irq_stat[IRQ_UDF_BIT] = r_udf;
      assign w_irq_ch[gc]            = |(w_irq_stat & r_ctrl.ien);

      // Read value of the addressed register in this channel
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      always_comb begin
         w_word = '0;
         unique case (w_reg)
            REG_DATA:   w_word = w_rx_empty ? EMPTY_READ_VALUE : 32'(w_rx_head);
            REG_STATUS: w_word = {16'(DEPTH - w_tx_level), 16'(w_rx_level)};
            REG_CTRL:   w_word = {7'd0, r_ctrl.lb, r_ctrl.tx_thr, r_ctrl.rx_thr, 4'd0, r_ctrl.ien};
            REG_IRQ:    w_word = {16'd0, w_drop, 4'd0, w_irq_stat};
         endcase
      end

      assign w_rd_words[gc*32 +: 32]        = w_word;
      assign rx_ready_o[gc]                 = r_run & ~r_ctrl.lb & ~w_rx_full;
      assign tx_valid_o[gc]                 = ~r_ctrl.lb & ~w_tx_empty;
      assign tx_data_o[gc*DATA_W +: DATA_W] = w_tx_head;
   end

   // Channel select; unimplemented channels read the empty pattern
   always_comb begin
      w_rd_mux = EMPTY_READ_VALUE;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_ch == 2'(c)) w_rd_mux = w_rd_words[c*32 +: 32];
      end
   end

   assign WBs_DAT_o   = r_ack ? w_rd_mux : '0;
   assign WBs_ACK_o   = r_ack;
   assign Interrupt_o = r_irq;

endmodule

// File: tb/tb_wb_serial_fifo_bridge.sv
// Directed self-checking bench for wb_serial_fifo_bridge (2 channels,
// 8-bit data, depth 4). Inputs change on the falling edge; outputs are
// sampled on the falling edge.
module tb_wb_serial_fifo_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  adr;
   logic        cyc, stb, we;
   logic [3:0]  bstb;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        ack;
   logic [15:0] rx_data;
   logic [1:0]  rx_valid, rx_ready;
   logic [15:0] tx_data;
   logic [1:0]  tx_valid, tx_ready;
   logic        irq;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   logic [31:0] rd;
   logic [5:0]  ack_pat;
   logic [31:0] exp_irq1;

   always #5 clk = ~clk;

   wb_serial_fifo_bridge #(.NUM_CH(2), .DATA_W(8), .DEPTH_LOG2(2)) dut (
      .WBs_CLK_i(clk), .WBs_RSTn_i(rst_n), .WBs_ADR_i(adr), .WBs_CYC_i(cyc),
      .WBs_STB_i(stb), .WBs_WE_i(we), .WBs_BYTE_STB_i(bstb), .WBs_DAT_i(dat_w),
      .WBs_DAT_o(dat_r), .WBs_ACK_o(ack), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
      .rx_ready_o(rx_ready), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
      .tx_ready_i(tx_ready), .Interrupt_o(irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One Wishbone transfer starting at a falling edge; returns at the falling edge after the ACK cycle
   task automatic wb(input logic w, input logic [3:0] a, input logic [31:0] d, output logic [31:0] r);
      logic got = 1'b0;
      r   = '0;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge clk);
         if (ack) begin
            got = 1'b1;
            r   = dat_r;
         end
      end
      check("ack_seen", 32'(got), 32'd1);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic rx_push(input int ch, input logic [7:0] d);
      rx_data[ch*8 +: 8] = d;
      rx_valid[ch] = 1'b1;
      @(negedge clk);
      rx_valid[ch] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; adr = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; bstb = 4'hF; dat_w = '0;
      rx_data = '0; rx_valid = '0; tx_ready = '0;

      // Reset values
      @(negedge clk); @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_dat", dat_r, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_txv", 32'(tx_valid), 32'd0);
      check("rst_rxr", 32'(rx_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rxr_after_rst", 32'(rx_ready), 32'd3);

      wb(1'b0, 4'b0001, '0, rd); check("status0_init", rd, 32'h0004_0000);

      // RX path, empty read and underflow
      rx_push(0, 8'h11); rx_push(0, 8'h22); rx_push(0, 8'h33);
      wb(1'b0, 4'b0000, '0, rd); check("rx_rd1", rd, 32'h11);
      wb(1'b0, 4'b0000, '0, rd); check("rx_rd2", rd, 32'h22);
      wb(1'b0, 4'b0000, '0, rd); check("rx_rd3", rd, 32'h33);
      wb(1'b0, 4'b0000, '0, rd); check("rx_rd_empty", rd, 32'hBADF_ABAC);
      wb(1'b0, 4'b0011, '0, rd); check("irq0_udf", rd, 32'h0000_000B);
      wb(1'b1, 4'b0011, 32'h8, rd);
      wb(1'b0, 4'b0011, '0, rd); check("irq0_udf_clr", rd, 32'h0000_0003);

      // Unimplemented channel
      wb(1'b0, 4'b1000, '0, rd); check("ch2_data", rd, 32'hBADF_ABAC);
      wb(1'b1, 4'b1010, 32'hFF, rd);
      wb(1'b0, 4'b1010, '0, rd); check("ch2_ctrl", rd, 32'hBADF_ABAC);

      // TX overflow on channel 1 with the peripheral stalled
      for (int i = 0; i < 5; i++) wb(1'b1, 4'b0100, 32'hA1 + 32'(i), rd);
      wb(1'b0, 4'b0101, '0, rd); check("status1_full", rd, 32'h0000_0000);
`ifdef WB_FIFO_BRIDGE_DROP_CNT_EN
      exp_irq1 = 32'h0000_0105;
`else
      exp_irq1 = 32'h0000_0005;
`endif
      wb(1'b0, 4'b0111, '0, rd); check("irq1_ovf", rd, exp_irq1);
      check("tx0_idle", 32'(tx_valid[0]), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("tx1_valid", 32'(tx_valid[1]), 32'd1);
         check("tx1_data", 32'(tx_data[15:8]), 32'hA1 + 32'(i));
         tx_ready[1] = 1'b1;
         @(negedge clk);
      end
      tx_ready[1] = 1'b0;
      check("tx1_drained", 32'(tx_valid[1]), 32'd0);

      // RX threshold interrupt
      wb(1'b1, 4'b0010, 32'h0000_0201, rd);
      wb(1'b0, 4'b0010, '0, rd); check("ctrl0_rb", rd, 32'h0000_0201);
      check("irq_low", 32'(irq), 32'd0);
      rx_push(0, 8'h44); rx_push(0, 8'h55);
      check("irq_lat", 32'(irq), 32'd0);
      @(negedge clk);
      check("irq_high", 32'(irq), 32'd1);
      wb(1'b0, 4'b0000, '0, rd); check("irq_rd", rd, 32'h44);
      @(negedge clk);
      check("irq_fall", 32'(irq), 32'd0);
      wb(1'b0, 4'b0000, '0, rd); check("irq_rd2", rd, 32'h55);

      // Loopback
      wb(1'b1, 4'b0010, 32'h0100_0000, rd);
      wb(1'b1, 4'b0000, 32'hA5, rd);
      check("lb_txv", 32'(tx_valid[0]), 32'd0);
      check("lb_rxr", 32'(rx_ready[0]), 32'd0);
      @(negedge clk);
      check("lb_txv2", 32'(tx_valid[0]), 32'd0);
      wb(1'b0, 4'b0000, '0, rd); check("lb_data", rd, 32'hA5);
      wb(1'b1, 4'b0010, 32'h0, rd);

      // Full RX with simultaneous valid and DATA read
      for (int i = 0; i < 4; i++) begin
         rx_data[7:0] = 8'h61 + 8'(i);
         rx_valid[0] = 1'b1;
         @(negedge clk);
      end
      rx_data[7:0] = 8'h65;
      check("full_rxr0", 32'(rx_ready[0]), 32'd0);
      wb(1'b0, 4'b0000, '0, rd); check("full_rd", rd, 32'h61);
      check("full_rxr_rise", 32'(rx_ready[0]), 32'd1);
      @(negedge clk);
      check("full_rxr_refill", 32'(rx_ready[0]), 32'd0);
      rx_valid[0] = 1'b0;
      wb(1'b0, 4'b0001, '0, rd); check("full_status", rd, 32'h0004_0004);
      for (int i = 0; i < 4; i++) begin
         wb(1'b0, 4'b0000, '0, rd); check("full_drain", rd, 32'h62 + 32'(i));
      end

      // Back-to-back request: ACK every second cycle
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ack_pat[i] = ack;
      end
      cyc = 1'b0; stb = 1'b0;
      check("b2b_ack", 32'(ack_pat), 32'h15);
      @(negedge clk);

      // Reset during a pending write
      wb(1'b1, 4'b0100, 32'h99, rd);
      check("pre_rst_txv", 32'(tx_valid[1]), 32'd1);
      wb(1'b1, 4'b0010, 32'h0000_0F01, rd);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'b0100; dat_w = 32'h77;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ack", 32'(ack), 32'd0);
      check("mid_rst_dat", dat_r, 32'd0);
      check("mid_rst_irq", 32'(irq), 32'd0);
      check("mid_rst_txv", 32'(tx_valid), 32'd0);
      check("mid_rst_rxr", 32'(rx_ready), 32'd0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk); @(negedge clk);
      check("in_rst_ack", 32'(ack), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ack", 32'(ack), 32'd0);
      check("post_rst_txv", 32'(tx_valid), 32'd0);
      check("post_rst_rxr", 32'(rx_ready), 32'd3);
      wb(1'b0, 4'b0101, '0, rd); check("post_rst_status1", rd, 32'h0004_0000);
      wb(1'b0, 4'b0010, '0, rd); check("post_rst_ctrl0", rd, 32'h0);
      wb(1'b0, 4'b0111, '0, rd); check("post_rst_irq1", rd, 32'h0000_0003);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
